fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage of the pipelined CPU, directly upstream of decode. It owns the fetch PC and drives the address of the synchronous instruction-memory read port. Each cycle it presents decode with an instruction word, its PC, and a bubble flag. It holds the presented instruction across decode stalls and redirects to a branch target on flush.

## Interface
Parameters:
- RESET_PC, 16'h0000: fetch address loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  from decode: hold the currently presented instruction for another cycle.
- flush  in  1  from execute: taken branch/jump; discard in-flight fetch and redirect.
- branch_tgt  in  16  redirect address, sampled when flush=1.
- halt  in  1  from writeback: stop fetching; sticky until rst.
- mem_addr  out  16  instruction-memory read address (word-addressed).
- mem_data  in  16  instruction word; valid one cycle after mem_addr is presented.
- instr_out  out  16  instruction to decode (mem_out_1).
- pc_out  out  16  PC of instr_out (pc_in of decode).
- bubble_out  out  1  1 = instr_out is not a real instruction (bubble_in of decode).

## Operation
- State: fetch PC F (16b), pc_out (16b), bubble_out, hold_instr (16b), hold_valid, halted.
- mem_addr = F, driven directly from the register with no combinational path from inputs.
- instr_out = hold_valid ? hold_instr : mem_data.
- Each edge uses this priority: rst > halt/halted > flush > stall > normal.
- Reset: F=RESET_PC, pc_out=0, bubble_out=1, hold_instr=0, hold_valid=0, halted=0.
- halt=1 or halted: set halted=1 and bubble_out=1; F, pc_out and hold state are frozen. Only rst clears halted.
- Flush:
  - F <= branch_tgt, bubble_out <= 1, hold_valid <= 0.
  - pc_out is don't-care but is held.
  - Flush overrides a simultaneous stall.
- Stall (no flush):
  - F, pc_out and bubble_out are held.
  - If hold_valid=0: hold_instr <= mem_data, hold_valid <= 1. If already 1, the contents are kept.
- Normal: pc_out <= F, F <= F+1, bubble_out <= 0, hold_valid <= 0.
- F+1 wraps 16'hFFFF -> 16'h0000 with no flag.
- A stall arriving while bubble_out=1 is legal and is treated identically.

## Timing
- Memory latency is 1 cycle: the address presented in cycle n returns data in cycle n+1.
- After rst deassert (cycle 0, F=RESET_PC), decode sees the first real instruction in cycle 1: pc_out=RESET_PC, bubble_out=0.
- Flush in cycle n:
  - Cycle n+1: bubble_out=1, mem_addr=branch_tgt.
  - Cycle n+2: instr_out=mem[branch_tgt], pc_out=branch_tgt, bubble_out=0.
  - Flush penalty is 1 bubble from fetch; decode adds its own.
- Stall asserted in cycle n with instr I at PC p:
  - instr_out=I and pc_out=p for cycle n+1 and for every further stalled cycle.
  - First cycle with stall=0 at cycle m: cycle m+1 presents mem[p+1] with pc_out=p+1, with no lost or duplicated instruction.
- Back-to-back flushes: the last one wins; a bubble is emitted every flushed cycle.
- rst mid-stall or mid-flush: all state is restored to reset values on that edge, and hold_instr is discarded.

## Test plan
- Reset/sequential:
  - Stimulus: RESET_PC=16'h0010, mem[a]=a^16'hA5A5, no stall/flush.
  - Required: cycle 0 bubble=1; cycles 1..8 give pc_out=0x10..0x17, instr_out=mem[pc_out], bubble=0.
- Single stall:
  - Stimulus: stall=1 for 1 cycle while pc_out=0x0003.
  - Required: pc_out=0x0003 with the same instr_out for 2 cycles, then 0x0004, 0x0005, each with its correct mem data.
- Multi-cycle stall:
  - Stimulus: stall=1 for 3 cycles.
  - Required: the held instr is stable for 4 cycles.
  - Required: the stream resumes at p+1; checked against a scoreboard to confirm no PC is skipped or repeated.
- Flush:
  - Stimulus: flush=1 with branch_tgt=0x0100 in cycle n, stall=1 in the same cycle.
  - Required: cycle n+1 bubble=1; cycle n+2 pc_out=0x0100, instr_out=mem[0x100].
- Wrap and halt:
  - Stimulus 1: flush to 0xFFFE.
  - Required: pc_out sequence 0xFFFE, 0xFFFF, 0x0000.
  - Stimulus 2: halt=1.
  - Required: bubble_out=1 and mem_addr frozen for 20 cycles.
  - Stimulus 3: rst.
  - Required: fetching restarts at RESET_PC.
- Reset mid-stall:
  - Stimulus: rst=1 while hold_valid=1.
  - Required: next cycle bubble_out=1, hold_valid=0; cycle after rst deassert gives pc_out=RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bundle of pipeline control, instruction-memory port and decode-side outputs.
interface fetch_if;
  logic stall, flush, halt, bubble_out;
  logic [15:0] branch_tgt, mem_addr, mem_data, instr_out, pc_out;
  modport master(input stall, flush, halt, branch_tgt, mem_data, output mem_addr, instr_out, pc_out, bubble_out);
  modport slave(output stall, flush, halt, branch_tgt, mem_data, input mem_addr, instr_out, pc_out, bubble_out);
endinterface

// File: rtl/fetch.sv
// fetch: instruction-fetch stage owning the fetch PC, with stall hold, flush redirect and sticky halt.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  logic [15:0] pc, pc_q, hold_instr;
  logic bubble, hold_valid, halted;
  assign bus.mem_addr = pc;
  assign bus.instr_out = hold_valid ? hold_instr : bus.mem_data;
  assign bus.pc_out = pc_q;
  assign bus.bubble_out = bubble;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pc_q <= 16'h0000;
      bubble <= 1'b1;
      hold_instr <= 16'h0000;
      hold_valid <= 1'b0;
      halted <= 1'b0;
    end else if (bus.halt || halted) begin
      halted <= 1'b1;
      bubble <= 1'b1;
    end else if (bus.flush) begin
      pc <= bus.branch_tgt;
      bubble <= 1'b1;
      hold_valid <= 1'b0;
    end else if (bus.stall) begin
      // memory data moves on next cycle, so capture the presented word once
      if (!hold_valid) begin
        hold_instr <= bus.mem_data;
        hold_valid <= 1'b1;
      end
    end else begin
      pc_q <= pc;
      pc <= pc + 16'd1;
      bubble <= 1'b0;
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized and directed checks of fetch against a delivered-stream reference model.
module tb_fetch;
  localparam logic [15:0] RPC = 16'h0010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_pc, nxt;
  logic m_bub, m_halt;
  fetch_if bus();
  fetch #(.RESET_PC(RPC)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction
  always @(posedge clk) bus.mem_data <= memf(bus.mem_addr);
  // model: nxt is the next PC decode should receive; m_pc/m_bub what it sees now
  task automatic cyc(input logic s, input logic fl, input logic [15:0] t, input logic h);
    bus.stall = s;
    bus.flush = fl;
    bus.branch_tgt = t;
    bus.halt = h;
    @(posedge clk);
    if (rst) begin
      m_pc = 16'h0000; m_bub = 1'b1; nxt = RPC; m_halt = 1'b0;
    end else if (h || m_halt) begin
      m_halt = 1'b1; m_bub = 1'b1;
    end else if (fl) begin
      m_bub = 1'b1; nxt = t;
    end else if (!s) begin
      m_pc = nxt; nxt = nxt + 16'd1; m_bub = 1'b0;
    end
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++; if (bus.bubble_out !== 1'b1) begin n_err++; $display("FAIL reset_bubble got %b exp 1", bus.bubble_out); end
    n_cmp++; if (bus.pc_out !== 16'h0000) begin n_err++; $display("FAIL reset_pc got %h exp 0000", bus.pc_out); end
    n_cmp++; if (bus.mem_addr !== RPC) begin n_err++; $display("FAIL reset_addr got %h exp %h", bus.mem_addr, RPC); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      n_cmp++; if (bus.pc_out !== RPC + 16'(i)) begin n_err++; $display("FAIL seq_pc got %h exp %h", bus.pc_out, RPC + 16'(i)); end
      n_cmp++; if (bus.bubble_out !== 1'b0) begin n_err++; $display("FAIL seq_bubble got %b exp 0", bus.bubble_out); end
      n_cmp++; if (bus.instr_out !== memf(RPC + 16'(i))) begin n_err++; $display("FAIL seq_instr got %h exp %h", bus.instr_out, memf(RPC + 16'(i))); end
    end
  endtask
  task automatic test_single_stall;
    logic [15:0] ep [4] = '{16'h0003, 16'h0003, 16'h0004, 16'h0005};
    cyc(0, 1, 16'h0003, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.pc_out !== ep[i] || bus.bubble_out !== 1'b0) begin n_err++; $display("FAIL stall1_pc got %h/%b exp %h/0", bus.pc_out, bus.bubble_out, ep[i]); end
      n_cmp++; if (bus.instr_out !== memf(ep[i])) begin n_err++; $display("FAIL stall1_instr got %h exp %h", bus.instr_out, memf(ep[i])); end
      if (i < 3) cyc(i == 0, 0, 0, 0);
    end
  endtask
  task automatic test_multi_stall;
    logic [15:0] p;
    p = m_pc;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      n_cmp++; if (bus.pc_out !== p || bus.instr_out !== memf(p)) begin n_err++; $display("FAIL stall3_hold got %h:%h exp %h:%h", bus.pc_out, bus.instr_out, p, memf(p)); end
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0);
      n_cmp++; if (bus.pc_out !== p + 16'(i) || bus.pc_out !== m_pc) begin n_err++; $display("FAIL stall3_resume got %h exp %h", bus.pc_out, p + 16'(i)); end
      n_cmp++; if (bus.instr_out !== memf(m_pc)) begin n_err++; $display("FAIL stall3_instr got %h exp %h", bus.instr_out, memf(m_pc)); end
    end
  endtask
  task automatic test_flush;
    cyc(1, 1, 16'h0100, 0);
    n_cmp++; if (bus.bubble_out !== 1'b1 || bus.mem_addr !== 16'h0100) begin n_err++; $display("FAIL flush_bubble got %b/%h exp 1/0100", bus.bubble_out, bus.mem_addr); end
    cyc(0, 0, 0, 0);
    n_cmp++; if (bus.pc_out !== 16'h0100 || bus.bubble_out !== 1'b0) begin n_err++; $display("FAIL flush_pc got %h/%b exp 0100/0", bus.pc_out, bus.bubble_out); end
    n_cmp++; if (bus.instr_out !== memf(16'h0100)) begin n_err++; $display("FAIL flush_instr got %h exp %h", bus.instr_out, memf(16'h0100)); end
  endtask
  task automatic test_back_to_back;
    cyc(0, 1, 16'h0200, 0);
    n_cmp++; if (bus.bubble_out !== 1'b1) begin n_err++; $display("FAIL b2b_bubble1 got %b exp 1", bus.bubble_out); end
    cyc(0, 1, 16'h0300, 0);
    n_cmp++; if (bus.bubble_out !== 1'b1) begin n_err++; $display("FAIL b2b_bubble2 got %b exp 1", bus.bubble_out); end
    cyc(0, 0, 0, 0);
    n_cmp++; if (bus.pc_out !== 16'h0300 || bus.instr_out !== memf(16'h0300)) begin n_err++; $display("FAIL b2b_last got %h:%h exp 0300:%h", bus.pc_out, bus.instr_out, memf(16'h0300)); end
  endtask
  task automatic test_wrap_halt;
    logic [15:0] ep [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [15:0] fa;
    cyc(0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      n_cmp++; if (bus.pc_out !== ep[i] || bus.instr_out !== memf(ep[i])) begin n_err++; $display("FAIL wrap_pc got %h:%h exp %h:%h", bus.pc_out, bus.instr_out, ep[i], memf(ep[i])); end
    end
    fa = nxt;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 16'($urandom), 0);
      n_cmp++; if (bus.bubble_out !== 1'b1 || bus.mem_addr !== fa) begin n_err++; $display("FAIL halt_freeze got %b/%h exp 1/%h", bus.bubble_out, bus.mem_addr, fa); end
    end
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    n_cmp++; if (bus.pc_out !== RPC || bus.bubble_out !== 1'b0) begin n_err++; $display("FAIL halt_restart got %h/%b exp %h/0", bus.pc_out, bus.bubble_out, RPC); end
  endtask
  task automatic test_reset_mid_stall;
    cyc(0, 1, 16'h0500, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0, 0);
    n_cmp++; if (bus.bubble_out !== 1'b1 || bus.pc_out !== 16'h0000 || bus.mem_addr !== RPC) begin n_err++; $display("FAIL rststall_state got %b/%h/%h exp 1/0000/%h", bus.bubble_out, bus.pc_out, bus.mem_addr, RPC); end
    cyc(1, 0, 0, 0);
    n_cmp++; if (bus.instr_out !== memf(RPC)) begin n_err++; $display("FAIL rststall_hold got %h exp %h", bus.instr_out, memf(RPC)); end
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    n_cmp++; if (bus.pc_out !== RPC || bus.instr_out !== memf(RPC) || bus.bubble_out !== 1'b0) begin n_err++; $display("FAIL rststall_restart got %h:%h exp %h:%h", bus.pc_out, bus.instr_out, RPC, memf(RPC)); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 16'($urandom), 0);
      n_cmp++; if (bus.bubble_out !== m_bub || bus.mem_addr !== nxt) begin n_err++; $display("FAIL rand_ctl got %b/%h exp %b/%h", bus.bubble_out, bus.mem_addr, m_bub, nxt); end
      if (!m_bub) begin
        n_cmp++; if (bus.pc_out !== m_pc || bus.instr_out !== memf(m_pc)) begin n_err++; $display("FAIL rand_instr got %h:%h exp %h:%h", bus.pc_out, bus.instr_out, m_pc, memf(m_pc)); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_single_stall;
    test_multi_stall;
    test_flush;
    test_back_to_back;
    test_random;
    test_wrap_halt;
    test_reset_mid_stall;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
